// File: rtl/rx_buffer_pkg.sv
// Shared address map and status layout for the UART receive/transmit buffers.
// Latency: n/a (constants, types and one helper function only).
// Backpressure: n/a.
package rx_buffer_pkg;

    // Receive buffer window: slots at BASE..BASE+DEPTH-1, status at BASE+DEPTH.
    localparam int RXB_BASE_ADDR = 10;
    localparam int RXB_DEPTH     = 4;
    localparam int RXB_STAT_OFS  = RXB_DEPTH;
    localparam int RXB_CNT_W     = 3;

    // Status register bit positions.
    localparam int STAT_FULL    = 0;
    localparam int STAT_OVR     = 1;
    localparam int STAT_CNT_LSB = 2;
    localparam int STAT_CNT_MSB = 4;

    // Transmit buffer window (6..9); kept here so the two windows stay disjoint.
    localparam int TXB_BASE_ADDR = 6;
    localparam int TXB_DEPTH     = 4;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_FULL = 1'b1
    } rxb_state_t;

    // Pack count and flags into the CPU-visible status byte.
    function automatic logic [7:0] rxb_status(input logic [RXB_CNT_W-1:0] cnt,
                                              input logic                 ovr,
                                              input logic                 is_full);
        logic [7:0] s;
        s                             = 8'h00;
        s[STAT_FULL]                  = is_full;
        s[STAT_OVR]                   = ovr;
        s[STAT_CNT_MSB:STAT_CNT_LSB]  = cnt;
        return s;
    endfunction

endpackage

// File: rtl/rx_buffer.sv
// Receive buffer: captures DEPTH bytes from the UART receiver, CPU reads them by address.
// Latency: 1 cycle from rd to r_data; full rises the cycle after the last byte is captured.
// Backpressure: none; bytes arriving while full are dropped and flagged via sticky overrun.
//
// Ports:
//   clk, reset            clock (rising edge), asynchronous active-high reset
//   rx_done_tick, rx_data byte-valid pulse and byte from the UART receiver
//   rd, address, r_data   CPU read strobe, 4-bit address, registered read data
//   clr                   CPU release pulse: restart filling, clear flags
//   full, overrun, count  buffer status
module rx_buffer
    import rx_buffer_pkg::*;
#(
    parameter int DEPTH     = RXB_DEPTH,
    parameter int BASE_ADDR = RXB_BASE_ADDR
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_done_tick,
    input  logic [7:0] rx_data,
    input  logic       rd,
    input  logic [3:0] address,
    input  logic       clr,
    output logic [7:0] r_data,
    output logic       full,
    output logic       overrun,
    output logic [2:0] count
);

    localparam int CNT_W = RXB_CNT_W;

    rxb_state_t       state;
    logic [7:0]       slots [DEPTH];
    logic [CNT_W-1:0] fill_cnt;
    logic             fill_open;
    logic             ovr_base;
    logic [7:0]       rd_mux;

    // A clr in the same cycle as a byte takes effect first, so the byte
    // lands in slot 0 of a freshly released buffer.
    always_comb begin
        fill_cnt  = clr ? '0 : count;
        fill_open = clr || (state == ST_FILL);
        ovr_base  = clr ? 1'b0 : overrun;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_FILL;
            count   <= '0;
            overrun <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                slots[i] <= 8'h00;
            end
        end else begin
            state   <= clr ? ST_FILL : state;
            count   <= fill_cnt;
            overrun <= ovr_base;
            if (rx_done_tick) begin
                if (fill_open) begin
                    count <= fill_cnt + CNT_W'(1);
                    if (fill_cnt == CNT_W'(DEPTH - 1)) begin
                        state <= ST_FULL;
                    end
                end else begin
                    overrun <= 1'b1;
                end
            end
            // Slot contents survive clr; only the fill pointer restarts.
            for (int i = 0; i < DEPTH; i++) begin
                if (rx_done_tick && fill_open && (fill_cnt == CNT_W'(i))) begin
                    slots[i] <= rx_data;
                end
            end
        end
    end

    // full is a decode of the state register, so it has no path from inputs.
    assign full = (state == ST_FULL);

    // Read mux sees pre-edge slot and status values, so a same-cycle write
    // or status change is not visible until the following read.
    always_comb begin
        rd_mux = 8'h00;
        for (int i = 0; i < DEPTH; i++) begin
            if (address == 4'(BASE_ADDR + i)) begin
                rd_mux = slots[i];
            end
        end
        if (address == 4'(BASE_ADDR + DEPTH)) begin
            rd_mux = rxb_status(count, overrun, full);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data <= 8'h00;
        end else if (rd) begin
            r_data <= rd_mux;
        end
    end

endmodule

// File: tb/tb_rx_buffer.sv
// Testbench for rx_buffer: directed scenarios plus randomized traffic checked
// against a queue-based reference model through a per-cycle scoreboard.
module tb_rx_buffer;

    localparam int DEPTH = 4;
    localparam int BASE  = 10;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_done_tick;
    logic [7:0] rx_data;
    logic       rd;
    logic [3:0] address;
    logic       clr;
    logic [7:0] r_data;
    logic       full;
    logic       overrun;
    logic [2:0] count;

    rx_buffer #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_done_tick (rx_done_tick),
        .rx_data      (rx_data),
        .rd           (rd),
        .address      (address),
        .clr          (clr),
        .r_data       (r_data),
        .full         (full),
        .overrun      (overrun),
        .count        (count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] rdata;
        logic [2:0] cnt;
        logic       ovr;
        logic       full;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    // Reference model: memory image, list of bytes captured since release,
    // sticky overrun and the last value the CPU read.
    logic [7:0] mem [DEPTH];
    logic [7:0] cap[$];
    logic       m_ovr;
    logic [7:0] m_rdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'h00;
        cap.delete();
        m_ovr   = 1'b0;
        m_rdata = 8'h00;
        exp_q.delete();
    endfunction

    function automatic logic [7:0] model_read(input logic [3:0] a);
        int ia;
        ia = int'(a);
        if (ia >= BASE && ia < BASE + DEPTH) return mem[ia - BASE];
        if (ia == BASE + DEPTH)
            return {3'b000, 3'(cap.size()), m_ovr, (cap.size() == DEPTH)};
        return 8'h00;
    endfunction

    // Drive one cycle of inputs and record what the DUT must show after that edge.
    task automatic step(input bit rx, input logic [7:0] d, input bit r,
                        input logic [3:0] a, input bit c);
        exp_t e;
        @(negedge clk);
        rx_done_tick = rx;
        rx_data      = d;
        rd           = r;
        address      = a;
        clr          = c;
        if (r) m_rdata = model_read(a);
        if (c) begin
            cap.delete();
            m_ovr = 1'b0;
        end
        if (rx) begin
            if (cap.size() < DEPTH) begin
                mem[cap.size()] = d;
                cap.push_back(d);
            end else begin
                m_ovr = 1'b1;
            end
        end
        e.rdata = m_rdata;
        e.cnt   = 3'(cap.size());
        e.ovr   = m_ovr;
        e.full  = (cap.size() == DEPTH);
        exp_q.push_back(e);
    endtask

    task automatic idle();
        step(1'b0, 8'h00, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Monitor: after every edge, compare the DUT against the oldest expectation.
    always @(posedge clk) begin
        #1;
        if (!reset && exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("r_data",  32'(r_data),  32'(mon_e.rdata));
            check("count",   32'(count),   32'(mon_e.cnt));
            check("overrun", 32'(overrun), 32'(mon_e.ovr));
            check("full",    32'(full),    32'(mon_e.full));
        end
    end

    initial begin
        reset        = 1'b1;
        rx_done_tick = 1'b0;
        rx_data      = 8'h00;
        rd           = 1'b0;
        address      = 4'd0;
        clr          = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_count",  32'(count),   32'd0);
        check("rst_full",   32'(full),    32'd0);
        check("rst_ovr",    32'(overrun), 32'd0);
        check("rst_rdata",  32'(r_data),  32'h00);

        // Reset mid-fill: two bytes, a read to make r_data non-zero, then async reset.
        step(1'b1, 8'hA1, 1'b0, 4'd0, 1'b0);
        step(1'b1, 8'hA2, 1'b0, 4'd0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 4'd10, 1'b0);
        settle();
        check("midfill_count", 32'(count),  32'd2);
        check("midfill_rdata", 32'(r_data), 32'hA1);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("async_count", 32'(count),   32'd0);
        check("async_full",  32'(full),    32'd0);
        check("async_ovr",   32'(overrun), 32'd0);
        check("async_rdata", 32'(r_data),  32'h00);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Fill and read back.
        step(1'b1, 8'h41, 1'b0, 4'd0, 1'b0);
        step(1'b1, 8'h42, 1'b0, 4'd0, 1'b0);
        step(1'b1, 8'h43, 1'b0, 4'd0, 1'b0);
        step(1'b1, 8'h44, 1'b0, 4'd0, 1'b0);
        settle();
        check("fill_full", 32'(full), 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 8'h00, 1'b1, 4'(BASE + i), 1'b0);
            settle();
            check("fill_slot", 32'(r_data), 32'(8'h41 + i));
        end
        step(1'b0, 8'h00, 1'b1, 4'd14, 1'b0);
        settle();
        check("stat_full", 32'(r_data), 32'h11);

        // Overrun.
        step(1'b1, 8'h55, 1'b0, 4'd0, 1'b0);
        settle();
        check("ovr_flag", 32'(overrun), 32'd1);
        step(1'b0, 8'h00, 1'b1, 4'd10, 1'b0);
        settle();
        check("ovr_slot0", 32'(r_data), 32'h41);
        step(1'b0, 8'h00, 1'b1, 4'd14, 1'b0);
        settle();
        check("stat_ovr", 32'(r_data), 32'h13);

        // Release.
        step(1'b0, 8'h00, 1'b0, 4'd0, 1'b1);
        step(1'b0, 8'h00, 1'b1, 4'd14, 1'b0);
        settle();
        check("stat_clr", 32'(r_data), 32'h00);
        check("clr_full", 32'(full),   32'd0);

        // Refill, then clr and a byte on the same edge.
        step(1'b1, 8'h41, 1'b0, 4'd0, 1'b0);
        step(1'b1, 8'h42, 1'b0, 4'd0, 1'b0);
        step(1'b1, 8'h43, 1'b0, 4'd0, 1'b0);
        step(1'b1, 8'h44, 1'b0, 4'd0, 1'b0);
        step(1'b1, 8'h7E, 1'b0, 4'd0, 1'b1);
        settle();
        check("sim_count", 32'(count),   32'd1);
        check("sim_full",  32'(full),    32'd0);
        check("sim_ovr",   32'(overrun), 32'd0);
        step(1'b0, 8'h00, 1'b1, 4'd10, 1'b0);
        settle();
        check("sim_slot0", 32'(r_data), 32'h7E);
        step(1'b0, 8'h00, 1'b1, 4'd11, 1'b0);
        settle();
        check("sim_slot1", 32'(r_data), 32'h42);

        // Out-of-window addresses, then hold with rd low while bytes arrive.
        step(1'b0, 8'h00, 1'b1, 4'd6, 1'b0);
        settle();
        check("oow_6", 32'(r_data), 32'h00);
        step(1'b0, 8'h00, 1'b1, 4'd15, 1'b0);
        settle();
        check("oow_15", 32'(r_data), 32'h00);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 8'(8'hC0 + i), 1'b0, 4'd10, 1'b0);
            settle();
            check("hold", 32'(r_data), 32'h00);
        end

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 2) == 0, 8'($urandom), $urandom_range(0, 1) == 1,
                 4'($urandom_range(0, 15)), $urandom_range(0, 15) == 0);
        end
        idle();

        // Bounded drain of the scoreboard.
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) settle();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
